// File: rtl/color_report_tx.sv
// Colour classifier with stability filter and a UART reporter that sends "#<letter>\n" per accepted class.
// Optional even-parity bit per byte when COLOR_REPORT_PARITY_EN is defined.
module color_report_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int STABLE_COUNT = 3
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic [9:0] red,
    input  logic [9:0] green,
    input  logic [9:0] blue,
    input  logic       sample_valid,
    output logic [1:0] class_out,
    output logic       class_valid,
    output logic       tx,
    output logic       busy
);

    localparam logic [1:0] CLS_RED   = 2'd0;
    localparam logic [1:0] CLS_GREEN = 2'd1;
    localparam logic [1:0] CLS_BLUE  = 2'd2;
    localparam logic [1:0] CLS_NONE  = 2'd3;

    localparam logic [3:0] STABLE = 4'(STABLE_COUNT);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    // NEXT occupies the final cycle of the stop bit, so STOP itself is one cycle short.
    localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT - 2);

`ifdef COLOR_REPORT_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, NEXT} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, NEXT} state_t;
`endif

    function automatic logic [7:0] letter_of(input logic [1:0] c);
        case (c)
            CLS_RED:   letter_of = 8'h4D;
            CLS_GREEN: letter_of = 8'h44;
            CLS_BLUE:  letter_of = 8'h57;
            default:   letter_of = 8'h00;
        endcase
    endfunction

    logic       discard;
    logic [1:0] cls_next;

    always_comb begin
        discard = (red <= 10'd80) || (green <= 10'd80) || (blue <= 10'd80);
        if (red > 10'd150 && red < 10'd250 && green > 10'd180 && green < 10'd270 &&
            blue > 10'd110 && blue < 10'd190)
            cls_next = CLS_GREEN;
        else if (red > 10'd280 && red < 10'd390 && green > 10'd70 && green < 10'd170 &&
                 blue > 10'd90 && blue < 10'd190)
            cls_next = CLS_RED;
        else if (red > 10'd70 && red < 10'd170 && green > 10'd80 && green < 10'd190 &&
                 blue > 10'd170 && blue < 10'd280)
            cls_next = CLS_BLUE;
        else
            cls_next = CLS_NONE;
    end

    logic [1:0] raw_class;
    logic [3:0] stab_cnt;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            raw_class <= CLS_NONE;
            stab_cnt  <= 4'd0;
        end else if (sample_valid && !discard) begin
            raw_class <= cls_next;
            if (cls_next == raw_class) begin
                if (stab_cnt < STABLE)
                    stab_cnt <= stab_cnt + 4'd1;
            end else begin
                stab_cnt <= 4'd1;
            end
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            class_out   <= CLS_NONE;
            class_valid <= 1'b0;
        end else begin
            class_valid <= 1'b0;
            if (stab_cnt == STABLE && raw_class != class_out) begin
                class_out   <= raw_class;
                class_valid <= 1'b1;
            end
        end
    end

    logic frame_req;
    assign frame_req = class_valid && (class_out != CLS_NONE);

    state_t        state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [1:0]    byte_idx;
    logic [7:0]    letter;
    logic [7:0]    pend_letter;
    logic          pend_vld;
    logic [7:0]    cur_byte;
    logic          bit_end;

    assign bit_end = (clk_cnt == BIT_LAST);

    always_comb begin
        case (byte_idx)
            2'd0:    cur_byte = 8'h23;
            2'd1:    cur_byte = letter;
            default: cur_byte = 8'h0A;
        endcase
    end

    // The letter is latched at frame start so later class events cannot alter a frame in flight.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_idx     <= 3'd0;
            byte_idx    <= 2'd0;
            letter      <= 8'h00;
            pend_letter <= 8'h00;
            pend_vld    <= 1'b0;
            tx          <= 1'b1;
            busy        <= 1'b0;
        end else begin
            if (frame_req && state != IDLE) begin
                pend_letter <= letter_of(class_out);
                pend_vld    <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (frame_req) begin
                        letter   <= letter_of(class_out);
                        byte_idx <= 2'd0;
                        clk_cnt  <= '0;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_idx <= 3'd0;
                        tx      <= cur_byte[0];
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef COLOR_REPORT_PARITY_EN
                            tx    <= ^cur_byte;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
`ifdef COLOR_REPORT_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        tx      <= 1'b1;
                        state   <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (clk_cnt == STOP_LAST) begin
                        clk_cnt <= '0;
                        state   <= NEXT;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                NEXT: begin
                    if (byte_idx != 2'd2) begin
                        byte_idx <= byte_idx + 2'd1;
                        tx       <= 1'b0;
                        state    <= START;
                    end else if (frame_req) begin
                        // A class accepted in the very last cycle is newer than any pending one.
                        letter   <= letter_of(class_out);
                        pend_vld <= 1'b0;
                        byte_idx <= 2'd0;
                        tx       <= 1'b0;
                        state    <= START;
                    end else if (pend_vld) begin
                        letter   <= pend_letter;
                        pend_vld <= 1'b0;
                        byte_idx <= 2'd0;
                        tx       <= 1'b0;
                        state    <= START;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_color_report_tx.sv
// Randomized bench for color_report_tx: a history/timeline model predicts class events and the tx waveform.
module tb_color_report_tx;

    localparam int CLKS   = 8;
    localparam int STABLE = 3;
`ifdef COLOR_REPORT_PARITY_EN
    localparam int BITS = 11;
`else
    localparam int BITS = 10;
`endif
    localparam int FRAME = 3 * BITS * CLKS;

    logic       clk_50 = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] red = '0, green = '0, blue = '0;
    logic       sample_valid = 1'b0;
    logic [1:0] class_out;
    logic       class_valid;
    logic       tx;
    logic       busy;

    color_report_tx #(.CLKS_PER_BIT(CLKS), .STABLE_COUNT(STABLE)) dut (
        .clk_50(clk_50), .rst_n(rst_n), .red(red), .green(green), .blue(blue),
        .sample_valid(sample_valid), .class_out(class_out), .class_valid(class_valid),
        .tx(tx), .busy(busy)
    );

    always #5 clk_50 = ~clk_50;

    int cyc = 0;
    always @(posedge clk_50) cyc <= cyc + 1;

    int n_cmp = 0, n_err = 0;
    bit run = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    typedef struct {int start; int letter;} frame_t;

    int     hist[$];
    int     cv_at[int];
    int     m_cls, vis_cls, busy_until, pend_letter;
    bit     pend_vld;
    frame_t fq[$];

    function automatic int classify(input int r, input int g, input int b);
        if (r > 150 && r < 250 && g > 180 && g < 270 && b > 110 && b < 190) return 1;
        if (r > 280 && r < 390 && g > 70 && g < 170 && b > 90 && b < 190) return 0;
        if (r > 70 && r < 170 && g > 80 && g < 190 && b > 170 && b < 280) return 2;
        return 3;
    endfunction

    function automatic int letter_of(input int c);
        return (c == 0) ? 'h4D : (c == 1) ? 'h44 : 'h57;
    endfunction

    task automatic model_reset();
        hist.delete(); cv_at.delete(); fq.delete();
        m_cls = 3; vis_cls = 3; busy_until = -100000; pend_vld = 0; pend_letter = 0;
    endtask

    always @(negedge clk_50) begin : mon
        bit          same, exp_cv;
        frame_t      fr;
        int          off, byt, pos, etx, ebusy;
        logic [7:0]  d;
        if (run) begin
            if (sample_valid && red > 80 && green > 80 && blue > 80) begin
                hist.push_back(classify(red, green, blue));
                if (hist.size() > STABLE) void'(hist.pop_front());
                same = 1;
                foreach (hist[i]) if (hist[i] != hist[0]) same = 0;
                if (hist.size() == STABLE && same && hist[0] != m_cls) begin
                    m_cls = hist[0];
                    cv_at[cyc + 2] = m_cls;
                end
            end
            exp_cv = cv_at.exists(cyc);
            if (exp_cv) begin
                vis_cls = cv_at[cyc];
                cv_at.delete(cyc);
            end
            chk("class_valid", class_valid, exp_cv);
            chk("class_out", class_out, vis_cls);
            if (exp_cv && vis_cls != 3) begin
                if (busy_until < cyc) begin
                    fr.start = cyc + 1; fr.letter = letter_of(vis_cls);
                    fq.push_back(fr); busy_until = cyc + FRAME;
                end else begin
                    pend_letter = letter_of(vis_cls); pend_vld = 1;
                end
            end
            if (pend_vld && cyc == busy_until) begin
                fr.start = cyc + 1; fr.letter = pend_letter;
                fq.push_back(fr); busy_until = cyc + FRAME; pend_vld = 0;
            end
            while (fq.size() > 0 && fq[0].start + FRAME - 1 < cyc) void'(fq.pop_front());
            etx = 1; ebusy = 0;
            if (fq.size() > 0 && fq[0].start <= cyc) begin
                ebusy = 1;
                off = cyc - fq[0].start;
                byt = off / (BITS * CLKS);
                pos = (off % (BITS * CLKS)) / CLKS;
                d = (byt == 0) ? 8'h23 : (byt == 1) ? 8'(fq[0].letter) : 8'h0A;
                if (pos == 0) etx = 0;
                else if (pos <= 8) etx = int'(d[pos-1]);
                else if (BITS == 11 && pos == 9) etx = int'(^d);
                else etx = 1;
            end
            chk("tx", tx, etx);
            chk("busy", busy, ebusy);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_50); #1; end
    endtask

    task automatic drive(input int r, input int g, input int b, input int gap);
        red = 10'(r); green = 10'(g); blue = 10'(b); sample_valid = 1'b1;
        @(posedge clk_50); #1;
        sample_valid = 1'b0;
        idle(gap);
    endtask

    task automatic gen(input int k, output int r, output int g, output int b);
        case (k)
            0: begin r = $urandom_range(281, 389); g = $urandom_range(71, 169); b = $urandom_range(91, 189); end
            1: begin r = $urandom_range(151, 249); g = $urandom_range(181, 269); b = $urandom_range(111, 189); end
            2: begin r = $urandom_range(71, 169); g = $urandom_range(81, 189); b = $urandom_range(171, 279); end
            3: begin
                r = $urandom_range(81, 600); g = $urandom_range(81, 600); b = $urandom_range(81, 600);
                case ($urandom_range(0, 2))
                    0: r = $urandom_range(0, 80);
                    1: g = $urandom_range(0, 80);
                    default: b = $urandom_range(0, 80);
                endcase
            end
            default: begin r = $urandom_range(81, 1023); g = $urandom_range(81, 1023); b = $urandom_range(81, 1023); end
        endcase
    endtask

    task automatic reset_dut();
        run = 0; rst_n = 1'b0; sample_valid = 1'b0;
        repeat (3) @(posedge clk_50);
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_class_out", class_out, 3);
        chk("rst_class_valid", class_valid, 0);
        rst_n = 1'b1;
        model_reset();
        run = 1;
    endtask

    initial begin
        int r, g, b, k, len;
        bit seen;
        reset_dut();
        idle(4);

        // three greens -> "#D\n"
        repeat (3) drive(200, 220, 150, 2);
        idle(FRAME + 20);
        chk("green_accepted", class_out, 1);

        // red, red, blue: never stable
        drive(300, 100, 120, 1); drive(300, 100, 120, 1); drive(100, 120, 200, 1);
        idle(40);
        chk("unstable_keeps_green", class_out, 1);

        // discarded sample between reds does not break the run
        drive(300, 100, 120, 1); drive(50, 300, 300, 1); drive(300, 100, 120, 1); drive(300, 100, 120, 1);
        idle(FRAME + 20);
        chk("red_after_discard", class_out, 0);

        // green frame in flight, then blue and red accepted: only red follows
        repeat (3) drive(200, 220, 150, 0);
        idle(30);
        repeat (3) drive(100, 120, 200, 0);
        idle(10);
        repeat (3) drive(300, 100, 120, 0);
        idle(2 * FRAME + 40);
        chk("overwrite_final_red", class_out, 0);

        // blue frame (carries parity 1 when enabled)
        repeat (3) drive(100, 120, 200, 1);
        idle(FRAME + 20);

        // reset in the middle of the letter byte
        repeat (3) drive(200, 220, 150, 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy) begin seen = 1; break; end
            idle(1);
        end
        chk("busy_rise", seen, 1);
        idle(BITS * CLKS + 5 * CLKS + 2);
        run = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_tx", tx, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_class_out", class_out, 3);
        chk("midrst_class_valid", class_valid, 0);
        idle(2);
        rst_n = 1'b1;
        model_reset();
        run = 1;
        idle(3 * BITS * CLKS);

        // random bursts
        for (int n = 0; n < 70; n++) begin
            k = $urandom_range(0, 4);
            len = $urandom_range(1, 4);
            for (int j = 0; j < len; j++) begin
                gen(k, r, g, b);
                drive(r, g, b, $urandom_range(0, 3));
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, FRAME));
        end
        idle(2 * FRAME + 50);
        chk("drain_events", cv_at.num(), 0);
        chk("drain_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
